// File: rtl/clock_time_setter.sv
// HH:MM:SS time keeper with three debounced buttons and a per-digit BCD set mode.
// Feeds hours/minutes/seconds, cursor position and set_mod to the display driver.
module clock_time_setter #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [2:0] pos,
  output logic       set_mod
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_SET} state_t;

  state_t state_q, state_d;

  logic [2:0]    raw;
  logic [2:0]    sync0_q, sync0_d, sync1_q, sync1_d;
  logic [2:0]    deb_q, deb_d, deb_dly_q, deb_dly_d, pulse_q, pulse_d;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];

  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    hours_q, hours_d, minutes_q, minutes_d, seconds_q, seconds_d;
  logic [2:0]    pos_q, pos_d;

  logic          mode_p, next_p, inc_p;
  logic [5:0]    s_t, s_u, m_t, m_u, h_t, h_u, h_lim, nt, nu;

  assign raw    = {btn_inc, btn_next, btn_mode};
  assign mode_p = pulse_q[0];
  assign next_p = pulse_q[1];
  assign inc_p  = pulse_q[2];

  // Counter runs only while the synchronised level disagrees with the debounced one,
  // so any bounce back to the old level restarts the qualification window.
  always_comb begin
    sync0_d   = raw;
    sync1_d   = sync0_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    pulse_d   = deb_q & ~deb_dly_q;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync1_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_MAX) deb_d[i] = sync1_q[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (mode_p) state_d = ST_SET;
      ST_SET:  if (mode_p) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    tick_d    = tick_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    pos_d     = pos_q;
    s_t   = seconds_q / 6'd10;
    s_u   = seconds_q % 6'd10;
    m_t   = minutes_q / 6'd10;
    m_u   = minutes_q % 6'd10;
    h_t   = hours_q / 6'd10;
    h_u   = hours_q % 6'd10;
    h_lim = (h_t == 6'd2) ? 6'd3 : 6'd9;
    nt    = '0;
    nu    = '0;
    case (state_q)
      ST_RUN: begin
        pos_d = '0;
        if (mode_p) begin
          tick_d = '0;
        end else if (tick_q == TICK_MAX) begin
          tick_d = '0;
          if (seconds_q == 6'd59) begin
            seconds_d = '0;
            if (minutes_q == 6'd59) begin
              minutes_d = '0;
              hours_d   = (hours_q == 6'd23) ? 6'd0 : hours_q + 6'd1;
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_SET: begin
        tick_d = '0;
        if (mode_p) begin
          pos_d = '0;
        end else if (next_p) begin
          pos_d = (pos_q >= 3'd5) ? 3'd0 : pos_q + 3'd1;
        end else if (inc_p) begin
          case (pos_q)
            3'd0: begin
              nu        = (s_u >= 6'd9) ? 6'd0 : s_u + 6'd1;
              seconds_d = s_t * 6'd10 + nu;
            end
            3'd1: begin
              nt        = (s_t >= 6'd5) ? 6'd0 : s_t + 6'd1;
              seconds_d = nt * 6'd10 + s_u;
            end
            3'd2: begin
              nu        = (m_u >= 6'd9) ? 6'd0 : m_u + 6'd1;
              minutes_d = m_t * 6'd10 + nu;
            end
            3'd3: begin
              nt        = (m_t >= 6'd5) ? 6'd0 : m_t + 6'd1;
              minutes_d = nt * 6'd10 + m_u;
            end
            3'd4: begin
              nu      = (h_u >= h_lim) ? 6'd0 : h_u + 6'd1;
              hours_d = h_t * 6'd10 + nu;
            end
            3'd5: begin
              nt      = (h_t >= 6'd2) ? 6'd0 : h_t + 6'd1;
              nu      = (nt == 6'd2 && h_u > 6'd3) ? 6'd3 : h_u;
              hours_d = nt * 6'd10 + nu;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    set_mod = (state_q == ST_SET);
    hours   = hours_q;
    minutes = minutes_q;
    seconds = seconds_q;
    pos     = pos_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      pulse_q   <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
      tick_q    <= '0;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      pos_q     <= '0;
    end else begin
      sync0_q   <= sync0_d;
      sync1_q   <= sync1_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      pulse_q   <= pulse_d;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      tick_q    <= tick_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      pos_q     <= pos_d;
    end
  end

endmodule
